// File: rtl/rv_ctrl_pkg.sv
// Shared opcode constants, field encodings and the control bundle that
// travels down the pipeline with each instruction.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_RFN  = 2'b10,
    ALU_IFN  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_t;

  // Fields are plain logic so a whole bundle can be cleared with '0.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       jump;
  } ctrl_t;

endpackage

// File: rtl/hazard_unit.sv
// Load-use stall, redirect flush and operand forwarding selects.
// Purely combinational from the pipeline register state and Decode fields.
module hazard_unit
  import rv_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs1_d,
  input  logic [RA_W-1:0] rs2_d,
  input  logic [RA_W-1:0] rs1_e,
  input  logic [RA_W-1:0] rs2_e,
  input  logic [RA_W-1:0] rd_e,
  input  logic [RA_W-1:0] rd_m,
  input  logic [RA_W-1:0] rd_w,
  input  logic [1:0]      result_src_e,
  input  logic            branch_e,
  input  logic            jump_e,
  input  logic            zero_e,
  input  logic            reg_write_m,
  input  logic            reg_write_w,
  output logic            pcsrc_e,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d,
  output logic            flush_e,
  output logic [1:0]      fwd_a_e,
  output logic [1:0]      fwd_b_e
);

  logic lw_stall;

  // Redirect, load-use detection and the stall/flush fan-out.
  always_comb begin
    pcsrc_e  = (branch_e & zero_e) | jump_e;
    lw_stall = (result_src_e == RES_MEM) && (rd_e != '0) &&
               ((rd_e == rs1_d) || (rd_e == rs2_d));
    stall_f  = lw_stall;
    stall_d  = lw_stall;
    flush_e  = lw_stall | pcsrc_e;
    flush_d  = pcsrc_e;
  end

  // Forwarding selects; the younger M result wins over W, x0 is never forwarded.
  always_comb begin
    fwd_a_e = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))      fwd_a_e = FWD_M;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e)) fwd_a_e = FWD_W;

    fwd_b_e = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))      fwd_b_e = FWD_M;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e)) fwd_b_e = FWD_W;
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes in Decode, carries the control bundle
// through ID/EX, EX/MEM and MEM/WB, and hosts the hazard unit.
module pipe_ctrl_unit
  import rv_ctrl_pkg::*;
#(
  parameter int RA_W    = 5,
  parameter bit EN_IALU = 1'b1,
  parameter bit EN_JAL  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [6:0]      op_d,
  input  logic [RA_W-1:0] rs1_d,
  input  logic [RA_W-1:0] rs2_d,
  input  logic [RA_W-1:0] rd_d,
  input  logic            zero_e,
  output logic            RegWrite_e,
  output logic            RegWrite_m,
  output logic            RegWrite_w,
  output logic            MemWrite_e,
  output logic            MemWrite_m,
  output logic [1:0]      ResultSrc_e,
  output logic [1:0]      ResultSrc_m,
  output logic [1:0]      ResultSrc_w,
  output logic            ALUSrc_e,
  output logic [1:0]      ALUop_e,
  output logic [2:0]      ImmSrc_d,
  output logic            PCSrc_e,
  output logic [RA_W-1:0] rd_e,
  output logic [RA_W-1:0] rd_m,
  output logic [RA_W-1:0] rd_w,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
  output logic [1:0]      ForwardA_e,
  output logic [1:0]      ForwardB_e,
  output logic            Illegal_d
);

  ctrl_t           ctrl_d;
  ctrl_t           ctrl_e;
  logic [RA_W-1:0] rs1_e;
  logic [RA_W-1:0] rs2_e;

  // Main decoder; unknown or disabled opcodes decode to an all-zero bubble.
  always_comb begin
    ctrl_d    = '0;
    ImmSrc_d  = IMM_I;
    Illegal_d = 1'b0;
    case (op_d)
      OP_LW: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = RES_MEM;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.alu_op     = ALU_ADD;
        ImmSrc_d          = IMM_I;
      end
      OP_SW: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_op    = ALU_ADD;
        ImmSrc_d         = IMM_S;
      end
      OP_RTYP: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = ALU_RFN;
      end
      OP_BEQ: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.alu_op = ALU_SUB;
        ImmSrc_d      = IMM_B;
      end
      OP_IALU: begin
        if (EN_IALU) begin
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_src   = 1'b1;
          ctrl_d.alu_op    = ALU_IFN;
          ImmSrc_d         = IMM_I;
        end else begin
          Illegal_d = 1'b1;
        end
      end
      OP_JAL: begin
        if (EN_JAL) begin
          ctrl_d.reg_write  = 1'b1;
          ctrl_d.jump       = 1'b1;
          ctrl_d.result_src = RES_PC4;
          ImmSrc_d          = IMM_J;
        end else begin
          Illegal_d = 1'b1;
        end
      end
      default: Illegal_d = 1'b1;
    endcase
  end

  // ID/EX: never stalled; a flush inserts a bubble with cleared branch/jump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_e <= '0;
      rd_e   <= '0;
      rs1_e  <= '0;
      rs2_e  <= '0;
    end else if (FlushE) begin
      ctrl_e <= '0;
      rd_e   <= '0;
      rs1_e  <= '0;
      rs2_e  <= '0;
    end else begin
      ctrl_e <= ctrl_d;
      rd_e   <= rd_d;
      rs1_e  <= rs1_d;
      rs2_e  <= rs2_d;
    end
  end

  // EX/MEM and MEM/WB advance every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite_m  <= 1'b0;
      MemWrite_m  <= 1'b0;
      ResultSrc_m <= '0;
      rd_m        <= '0;
      RegWrite_w  <= 1'b0;
      ResultSrc_w <= '0;
      rd_w        <= '0;
    end else begin
      RegWrite_m  <= ctrl_e.reg_write;
      MemWrite_m  <= ctrl_e.mem_write;
      ResultSrc_m <= ctrl_e.result_src;
      rd_m        <= rd_e;
      RegWrite_w  <= RegWrite_m;
      ResultSrc_w <= ResultSrc_m;
      rd_w        <= rd_m;
    end
  end

  // Execute-stage control outputs straight from ID/EX.
  always_comb begin
    RegWrite_e  = ctrl_e.reg_write;
    MemWrite_e  = ctrl_e.mem_write;
    ResultSrc_e = ctrl_e.result_src;
    ALUSrc_e    = ctrl_e.alu_src;
    ALUop_e     = ctrl_e.alu_op;
  end

  hazard_unit #(.RA_W(RA_W)) u_hazard (
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .rd_e         (rd_e),
    .rd_m         (rd_m),
    .rd_w         (rd_w),
    .result_src_e (ctrl_e.result_src),
    .branch_e     (ctrl_e.branch),
    .jump_e       (ctrl_e.jump),
    .zero_e       (zero_e),
    .reg_write_m  (RegWrite_m),
    .reg_write_w  (RegWrite_w),
    .pcsrc_e      (PCSrc_e),
    .stall_f      (StallF),
    .stall_d      (StallD),
    .flush_d      (FlushD),
    .flush_e      (FlushE),
    .fwd_a_e      (ForwardA_e),
    .fwd_b_e      (ForwardB_e)
  );

  // A load in Execute is never a branch or jump, so stall and redirect never coincide.
  stall_redirect_excl: assert property (@(posedge clk) disable iff (!rst_n) !(StallF && PCSrc_e));

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode table, pipeline latency,
// load-use stall, redirect flush, forwarding, reset and parameter gating.
module tb_pipe_ctrl_unit;
  import rv_ctrl_pkg::*;

  localparam int RA_W = 5;

  logic            clk;
  logic            rst_n;
  logic [6:0]      op_d;
  logic [RA_W-1:0] rs1_d, rs2_d, rd_d;
  logic            zero_e;

  logic            RegWrite_e, RegWrite_m, RegWrite_w, MemWrite_e, MemWrite_m;
  logic [1:0]      ResultSrc_e, ResultSrc_m, ResultSrc_w, ALUop_e;
  logic            ALUSrc_e, PCSrc_e, StallF, StallD, FlushD, FlushE, Illegal_d;
  logic [2:0]      ImmSrc_d;
  logic [RA_W-1:0] rd_e, rd_m, rd_w;
  logic [1:0]      ForwardA_e, ForwardB_e;

  logic            nj_RegWrite_e, nj_RegWrite_m, nj_RegWrite_w, nj_MemWrite_e, nj_MemWrite_m;
  logic [1:0]      nj_ResultSrc_e, nj_ResultSrc_m, nj_ResultSrc_w, nj_ALUop_e;
  logic            nj_ALUSrc_e, nj_PCSrc_e, nj_StallF, nj_StallD, nj_FlushD, nj_FlushE, nj_Illegal_d;
  logic [2:0]      nj_ImmSrc_d;
  logic [RA_W-1:0] nj_rd_e, nj_rd_m, nj_rd_w;
  logic [1:0]      nj_ForwardA_e, nj_ForwardB_e;

  int checks;
  int errors;

  pipe_ctrl_unit #(.RA_W(RA_W), .EN_IALU(1'b1), .EN_JAL(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .op_d(op_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .zero_e(zero_e), .RegWrite_e(RegWrite_e), .RegWrite_m(RegWrite_m), .RegWrite_w(RegWrite_w),
    .MemWrite_e(MemWrite_e), .MemWrite_m(MemWrite_m), .ResultSrc_e(ResultSrc_e),
    .ResultSrc_m(ResultSrc_m), .ResultSrc_w(ResultSrc_w), .ALUSrc_e(ALUSrc_e), .ALUop_e(ALUop_e),
    .ImmSrc_d(ImmSrc_d), .PCSrc_e(PCSrc_e), .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardA_e(ForwardA_e), .ForwardB_e(ForwardB_e), .Illegal_d(Illegal_d)
  );

  pipe_ctrl_unit #(.RA_W(RA_W), .EN_IALU(1'b0), .EN_JAL(1'b0)) u_dut_nj (
    .clk(clk), .rst_n(rst_n), .op_d(op_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .zero_e(zero_e), .RegWrite_e(nj_RegWrite_e), .RegWrite_m(nj_RegWrite_m),
    .RegWrite_w(nj_RegWrite_w), .MemWrite_e(nj_MemWrite_e), .MemWrite_m(nj_MemWrite_m),
    .ResultSrc_e(nj_ResultSrc_e), .ResultSrc_m(nj_ResultSrc_m), .ResultSrc_w(nj_ResultSrc_w),
    .ALUSrc_e(nj_ALUSrc_e), .ALUop_e(nj_ALUop_e), .ImmSrc_d(nj_ImmSrc_d), .PCSrc_e(nj_PCSrc_e),
    .rd_e(nj_rd_e), .rd_m(nj_rd_m), .rd_w(nj_rd_w), .StallF(nj_StallF), .StallD(nj_StallD),
    .FlushD(nj_FlushD), .FlushE(nj_FlushE), .ForwardA_e(nj_ForwardA_e),
    .ForwardB_e(nj_ForwardB_e), .Illegal_d(nj_Illegal_d)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction in Decode and let combinational outputs settle.
  task automatic drive_d(input logic [6:0] op, input logic [RA_W-1:0] rs1,
                         input logic [RA_W-1:0] rs2, input logic [RA_W-1:0] rd);
    op_d  = op;
    rs1_d = rs1;
    rs2_d = rs2;
    rd_d  = rd;
    #1;
  endtask

  task automatic drive_bubble();
    drive_d(7'b0000000, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    zero_e = 1'b0;
    drive_bubble();

    // Reset state.
    step();
    check("rst_regwrite_e", RegWrite_e, 0);
    check("rst_regwrite_w", RegWrite_w, 0);
    check("rst_rd_w", rd_w, 0);
    check("rst_fwd_a", ForwardA_e, 0);
    check("rst_stallf", StallF, 0);
    check("rst_illegal_op0", Illegal_d, 1);
    step();
    rst_n = 1'b1;

    // R-type latency through the pipe.
    drive_d(OP_RTYP, 5'd1, 5'd2, 5'd3);
    check("r_illegal", Illegal_d, 0);
    check("r_immsrc", ImmSrc_d, 3'b000);
    step();
    check("r_regwrite_e", RegWrite_e, 1);
    check("r_aluop_e", ALUop_e, 2'b10);
    check("r_alusrc_e", ALUSrc_e, 0);
    check("r_rd_e", rd_e, 3);
    drive_d(7'b1111111, 5'd0, 5'd0, 5'd0);
    check("unk_illegal", Illegal_d, 1);
    check("unk_nj_illegal", nj_Illegal_d, 1);
    step();
    check("r_regwrite_m", RegWrite_m, 1);
    check("r_rd_m", rd_m, 3);
    check("unk_regwrite_e", RegWrite_e, 0);
    check("unk_memwrite_e", MemWrite_e, 0);
    check("unk_alusrc_e", ALUSrc_e, 0);
    check("unk_aluop_e", ALUop_e, 0);
    check("unk_resultsrc_e", ResultSrc_e, 0);
    step();
    check("r_regwrite_w", RegWrite_w, 1);
    check("r_rd_w", rd_w, 3);
    check("r_resultsrc_w", ResultSrc_w, 0);

    // Load-use stall on x5.
    drive_d(OP_LW, 5'd0, 5'd0, 5'd5);
    check("lw_immsrc", ImmSrc_d, 3'b000);
    step();
    check("lw_resultsrc_e", ResultSrc_e, 2'b01);
    check("lw_alusrc_e", ALUSrc_e, 1);
    drive_d(OP_RTYP, 5'd5, 5'd6, 5'd7);
    check("lu_stallf", StallF, 1);
    check("lu_stalld", StallD, 1);
    check("lu_flushe", FlushE, 1);
    check("lu_flushd", FlushD, 0);
    check("lu_pcsrc", PCSrc_e, 0);
    step();
    check("lu_bubble_regwrite_e", RegWrite_e, 0);
    check("lu_bubble_rd_e", rd_e, 0);
    check("lu_lw_resultsrc_m", ResultSrc_m, 2'b01);
    check("lu_lw_rd_m", rd_m, 5);
    check("lu_released", StallF, 0);
    step();
    check("lu_r_regwrite_e", RegWrite_e, 1);
    check("lu_r_rd_e", rd_e, 7);
    check("lu_fwd_a_w", ForwardA_e, 2'b01);
    check("lu_fwd_b_none", ForwardB_e, 2'b00);
    drive_bubble();

    // Load to x0 never stalls.
    drive_d(OP_LW, 5'd0, 5'd0, 5'd0);
    step();
    drive_d(OP_RTYP, 5'd0, 5'd0, 5'd1);
    check("lw0_stallf", StallF, 0);
    check("lw0_flushe", FlushE, 0);
    step();
    drive_bubble();

    // Branch redirect.
    drive_d(OP_BEQ, 5'd1, 5'd2, 5'd0);
    check("beq_immsrc", ImmSrc_d, 3'b010);
    step();
    drive_bubble();
    check("beq_aluop_e", ALUop_e, 2'b01);
    zero_e = 1'b1;
    #1;
    check("beq_t_pcsrc", PCSrc_e, 1);
    check("beq_t_flushd", FlushD, 1);
    check("beq_t_flushe", FlushE, 1);
    check("beq_t_stallf", StallF, 0);
    zero_e = 1'b0;
    #1;
    check("beq_nt_pcsrc", PCSrc_e, 0);
    check("beq_nt_flushd", FlushD, 0);
    check("beq_nt_flushe", FlushE, 0);
    // Taken branch flushes a following beq, which must not redirect again.
    drive_d(OP_BEQ, 5'd1, 5'd2, 5'd0);
    zero_e = 1'b1;
    #1;
    check("beq_b2b_first", PCSrc_e, 1);
    step();
    check("beq_b2b_second", PCSrc_e, 0);
    zero_e = 1'b0;
    drive_bubble();

    // Forwarding: x4 written in M and W.
    drive_d(OP_IALU, 5'd0, 5'd0, 5'd4);
    check("ialu_immsrc", ImmSrc_d, 3'b000);
    check("ialu_nj_illegal", nj_Illegal_d, 1);
    step();
    check("ialu_aluop_e", ALUop_e, 2'b11);
    check("ialu_alusrc_e", ALUSrc_e, 1);
    drive_d(OP_RTYP, 5'd0, 5'd0, 5'd4);
    step();
    drive_d(OP_RTYP, 5'd4, 5'd4, 5'd9);
    step();
    check("fwd_mw_a", ForwardA_e, 2'b10);
    check("fwd_mw_b", ForwardB_e, 2'b10);
    drive_bubble();

    // Only W writes x4; the store in M carries rd=4 without RegWrite.
    drive_d(OP_RTYP, 5'd0, 5'd0, 5'd4);
    step();
    drive_d(OP_SW, 5'd0, 5'd0, 5'd4);
    check("sw_immsrc", ImmSrc_d, 3'b001);
    step();
    check("sw_memwrite_e", MemWrite_e, 1);
    drive_d(OP_RTYP, 5'd4, 5'd0, 5'd10);
    step();
    check("sw_memwrite_m", MemWrite_m, 1);
    check("fwd_w_a", ForwardA_e, 2'b01);
    check("fwd_w_b", ForwardB_e, 2'b00);
    drive_bubble();

    // Writes to x0 in both M and W are never forwarded.
    drive_d(OP_RTYP, 5'd0, 5'd0, 5'd0);
    step();
    step();
    drive_d(OP_RTYP, 5'd0, 5'd0, 5'd1);
    step();
    check("fwd_x0_a", ForwardA_e, 2'b00);
    check("fwd_x0_b", ForwardB_e, 2'b00);
    drive_bubble();

    // JAL redirect and PC+4 writeback.
    drive_d(OP_JAL, 5'd0, 5'd0, 5'd1);
    check("jal_illegal", Illegal_d, 0);
    check("jal_immsrc", ImmSrc_d, 3'b011);
    check("jal_nj_illegal", nj_Illegal_d, 1);
    step();
    drive_bubble();
    check("jal_pcsrc", PCSrc_e, 1);
    check("jal_flushd", FlushD, 1);
    check("jal_resultsrc_e", ResultSrc_e, 2'b10);
    check("jal_nj_pcsrc", nj_PCSrc_e, 0);
    step();

    // Reset mid-operation discards in-flight control.
    drive_d(OP_RTYP, 5'd0, 5'd0, 5'd2);
    step();
    rst_n = 1'b0;
    #1;
    check("mrst_regwrite_e", RegWrite_e, 0);
    check("mrst_rd_e", rd_e, 0);
    check("mrst_regwrite_m", RegWrite_m, 0);
    step();
    rst_n = 1'b1;
    drive_d(OP_RTYP, 5'd0, 5'd0, 5'd2);
    step();
    check("mrst_after_regwrite_e", RegWrite_e, 1);
    check("mrst_after_rd_e", rd_e, 2);
    drive_bubble();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
